// File: rtl/sha3_pkg.sv
// Shared types and constant tables for the SHA3 absorb/squeeze controller.
package sha3_pkg;

  localparam int unsigned SHA3_LANE_W = 64;
  localparam int unsigned SHA3_IDX_W  = 5;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } mode_t;

  // Indexed by mode: lanes absorbed per block and digest lanes emitted.
  localparam logic [SHA3_IDX_W-1:0] RATE_LANES [4] = '{5'd18, 5'd17, 5'd13, 5'd9};
  localparam logic [SHA3_IDX_W-1:0] OUT_LANES  [4] = '{5'd4, 5'd4, 5'd6, 5'd8};

  localparam logic [SHA3_LANE_W-1:0] PAD_DOMAIN = 64'h06;
  localparam logic [SHA3_LANE_W-1:0] PAD_FINAL  = 64'h8000000000000000;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PAD,
    PERM,
    SQUEEZE
  } ctrl_state_t;

endpackage

// File: rtl/sha3_absorb_ctrl.sv
// SHA3 sequencer: absorbs AXI-Stream lanes into an external Keccak state,
// applies pad10*1, drives the permutation handshake and streams the digest.
module sha3_absorb_ctrl
  import sha3_pkg::*;
#(
  parameter int unsigned LANE_W = SHA3_LANE_W,
  parameter int unsigned IDX_W  = SHA3_IDX_W
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [LANE_W-1:0] S_TDATA,
  input  logic              S_TVALID,
  output logic              S_TREADY,
  input  logic              S_TLAST,
  input  logic [1:0]        S_TUSER,
  output logic              xor_we,
  output logic [IDX_W-1:0]  xor_idx,
  output logic [LANE_W-1:0] xor_data,
  output logic              state_clr,
  output logic              perm_start,
  input  logic              perm_done,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [LANE_W-1:0] rd_data,
  output logic [LANE_W-1:0] M_TDATA,
  output logic              M_TVALID,
  input  logic              M_TREADY,
  output logic              M_TLAST,
  output logic [LANE_W/8-1:0] M_TKEEP
);

  localparam int unsigned KEEP_W = LANE_W / 8;

  ctrl_state_t      state, state_nxt;
  mode_t            mode, mode_nxt;
  logic [IDX_W-1:0] lane_cnt, lane_cnt_nxt;
  logic [IDX_W-1:0] pad_cnt, pad_cnt_nxt;
  logic [IDX_W-1:0] out_cnt, out_cnt_nxt;
  logic             msg_done, msg_done_nxt;
  logic             pad_pending, pad_pending_nxt;
  logic             first_pad, first_pad_nxt;
  logic             armed;
  logic             perm_start_q;

  logic [IDX_W-1:0] rate_m1;
  logic [IDX_W-1:0] out_m1;
  logic             last_beat;

  assign rate_m1    = IDX_W'(RATE_LANES[mode] - 5'd1);
  assign out_m1     = IDX_W'(OUT_LANES[mode] - 5'd1);
  assign last_beat  = (out_cnt == out_m1);
  assign perm_start = perm_start_q;

  // State and counter registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= IDLE;
      mode         <= MODE_224;
      lane_cnt     <= '0;
      pad_cnt      <= '0;
      out_cnt      <= '0;
      msg_done     <= 1'b0;
      pad_pending  <= 1'b0;
      first_pad    <= 1'b0;
      armed        <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      mode         <= mode_nxt;
      lane_cnt     <= lane_cnt_nxt;
      pad_cnt      <= pad_cnt_nxt;
      out_cnt      <= out_cnt_nxt;
      msg_done     <= msg_done_nxt;
      pad_pending  <= pad_pending_nxt;
      first_pad    <= first_pad_nxt;
      armed        <= 1'b1;
      // Pulse only on entry so a long permutation sees a single start.
      perm_start_q <= (state_nxt == PERM) && (state != PERM);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt       = state;
    mode_nxt        = mode;
    lane_cnt_nxt    = lane_cnt;
    pad_cnt_nxt     = pad_cnt;
    out_cnt_nxt     = out_cnt;
    msg_done_nxt    = msg_done;
    pad_pending_nxt = pad_pending;
    first_pad_nxt   = first_pad;
    S_TREADY        = 1'b0;
    xor_we          = 1'b0;
    xor_idx         = '0;
    xor_data        = '0;
    state_clr       = 1'b0;
    rd_idx          = '0;
    M_TDATA         = '0;
    M_TVALID        = 1'b0;
    M_TLAST         = 1'b0;
    M_TKEEP         = '0;

    unique case (state)
      IDLE: begin
        // armed keeps the first cycle after reset release fully quiet.
        if (armed && S_TVALID) begin
          mode_nxt        = mode_t'(S_TUSER);
          state_clr       = 1'b1;
          lane_cnt_nxt    = '0;
          msg_done_nxt    = 1'b0;
          pad_pending_nxt = 1'b0;
          state_nxt       = ABSORB;
        end
      end

      ABSORB: begin
        S_TREADY = 1'b1;
        xor_we   = S_TVALID;
        xor_idx  = lane_cnt;
        xor_data = S_TDATA;
        if (S_TVALID) begin
          if (lane_cnt == rate_m1) begin
            msg_done_nxt    = S_TLAST;
            pad_pending_nxt = S_TLAST;
            state_nxt       = PERM;
          end else if (S_TLAST) begin
            msg_done_nxt  = 1'b1;
            pad_cnt_nxt   = lane_cnt + 1'b1;
            first_pad_nxt = 1'b1;
            state_nxt     = PAD;
          end else begin
            lane_cnt_nxt = lane_cnt + 1'b1;
          end
        end
      end

      PAD: begin
        xor_we        = 1'b1;
        xor_idx       = pad_cnt;
        xor_data      = (first_pad ? PAD_DOMAIN : '0) | ((pad_cnt == rate_m1) ? PAD_FINAL : '0);
        first_pad_nxt = 1'b0;
        if (pad_cnt == rate_m1) begin
          pad_pending_nxt = 1'b0;
          state_nxt       = PERM;
        end else begin
          pad_cnt_nxt = pad_cnt + 1'b1;
        end
      end

      PERM: begin
        if (perm_done) begin
          if (pad_pending) begin
            pad_cnt_nxt   = '0;
            first_pad_nxt = 1'b1;
            state_nxt     = PAD;
          end else if (msg_done) begin
            out_cnt_nxt = '0;
            state_nxt   = SQUEEZE;
          end else begin
            lane_cnt_nxt = '0;
            state_nxt    = ABSORB;
          end
        end
      end

      SQUEEZE: begin
        rd_idx   = out_cnt;
        M_TDATA  = rd_data;
        M_TVALID = 1'b1;
        M_TLAST  = last_beat;
        M_TKEEP  = (last_beat && (mode == MODE_224)) ? KEEP_W'(8'h0F) : {KEEP_W{1'b1}};
        if (M_TREADY) begin
          if (last_beat) begin
            out_cnt_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            out_cnt_nxt = out_cnt + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
